// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the push-button bank front end (btn_bank_ctrl and
// btn_channel):
//   - default timing constants for a 50 MHz board clock
//   - counter width helper (clog2 wrapper that never returns zero)
//   - hold / auto-repeat FSM state encoding
// The hold FSM is only built when BTN_BANK_AUTOREPEAT_EN is defined; the
// state type is declared unconditionally so both builds share one package.
// -----------------------------------------------------------------------------
package btn_pkg;

  // Board clock the default timings are derived from.
  localparam int unsigned CLK_HZ = 50_000_000;

  // 1 ms debounce, 0.5 s hold before first repeat, 0.1 s repeat period.
  localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_HZ / 1000;
  localparam int unsigned DEF_HOLD_CYCLES     = CLK_HZ / 2;
  localparam int unsigned DEF_REPEAT_CYCLES   = CLK_HZ / 10;

  // Legal channel count range for one bank.
  localparam int unsigned MAX_BTN = 32;

  // Hold FSM states.
  typedef enum logic [1:0] {
    HS_IDLE   = 2'd0,  // released, or pressed before the down flag
    HS_HOLD   = 2'd1,  // pressed, waiting out the initial hold time
    HS_REPEAT = 2'd2   // pressed, issuing periodic repeat pulses
  } hold_state_e;

  // Width needed to hold values 0 .. n-1. A terminal count of 0 (n == 1)
  // still gets a 1-bit counter so no zero-width vectors are ever declared.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage : btn_pkg

// File: rtl/btn_channel.sv
// -----------------------------------------------------------------------------
// btn_channel
// One push-button channel: 2-flop synchroniser, polarity normalisation,
// counter-based debounce, registered press/release flags and (optionally)
// hold detection with auto-repeat.
//
// Optional feature macro: BTN_BANK_AUTOREPEAT_EN
//   defined   : hold FSM plus hold/repeat counters are built, repeat_o pulses
//   undefined : no hold logic, repeat_o is tied low, and the HOLD_CYCLES /
//               REPEAT_CYCLES parameters do not exist on this module
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous reset, active-high
//   btn_i     in   raw asynchronous button pin
//   state_o   out  debounced level, 1 = pressed
//   down_o    out  1-cycle pulse on accepted press
//   up_o      out  1-cycle pulse on accepted release
//   repeat_o  out  1-cycle pulse per auto-repeat tick
// -----------------------------------------------------------------------------
module btn_channel
  import btn_pkg::*;
#(
  parameter bit          ACTIVE_LOW      = 1'b1,
`ifdef BTN_BANK_AUTOREPEAT_EN
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
`endif
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic state_o,
  output logic down_o,
  output logic up_o,
  output logic repeat_o
);

  // Pin level that means "released"; the synchroniser resets to it so a
  // reset never looks like a press on its own.
  localparam logic RELEASED_LVL = ACTIVE_LOW;

  localparam int unsigned            DB_W    = cnt_width(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]        DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  logic sync1_q, sync2_q;

  // NOTE: clocked state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its source; blocking here would collapse
  // the two synchroniser stages into one.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= RELEASED_LVL;
      sync2_q <= RELEASED_LVL;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Normalised level: 1 = pressed, regardless of board polarity.
  logic pressed;
  assign pressed = ACTIVE_LOW ? ~sync2_q : sync2_q;

  // ---------------------------------------------------------------------------
  // Debounce
  // ---------------------------------------------------------------------------
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            state_q,  state_d;
  logic            down_q,   down_d;
  logic            up_q,     up_d;

  // NOTE: every signal driven here gets a default before any branch; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    db_cnt_d = db_cnt_q;
    state_d  = state_q;
    down_d   = 1'b0;
    up_d     = 1'b0;
    if (pressed == state_q) begin
      // Input agrees with the accepted level: any partial count is a glitch.
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      // Stable at the new level long enough: accept it and flag the edge.
      state_d  = pressed;
      db_cnt_d = '0;
      down_d   = pressed;
      up_d     = ~pressed;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt_q <= '0;
      state_q  <= 1'b0;
      down_q   <= 1'b0;
      up_q     <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      state_q  <= state_d;
      down_q   <= down_d;
      up_q     <= up_d;
    end
  end

  assign state_o = state_q;
  assign down_o  = down_q;
  assign up_o    = up_q;

  // ---------------------------------------------------------------------------
  // Hold / auto-repeat
  // ---------------------------------------------------------------------------
`ifdef BTN_BANK_AUTOREPEAT_EN
  localparam int unsigned         HOLD_W   = cnt_width(HOLD_CYCLES);
  localparam int unsigned         REP_W    = cnt_width(REPEAT_CYCLES);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [REP_W-1:0]    REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  hold_state_e       hs_q,       hs_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [REP_W-1:0]  rep_cnt_q,  rep_cnt_d;
  logic              repeat_q,   repeat_d;

  // The FSM reacts to the accept decision (down_d / up_d) rather than the
  // registered flags, so it changes state on the same edge the flag rises.
  // That lines the first repeat up exactly HOLD_CYCLES after the down flag
  // and lets an up decision suppress a repeat due on the same edge.
  always_comb begin
    hs_d       = hs_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    repeat_d   = 1'b0;
    if (up_d) begin
      hs_d       = HS_IDLE;
      hold_cnt_d = '0;
      rep_cnt_d  = '0;
    end else begin
      case (hs_q)
        HS_IDLE: begin
          if (down_d) begin
            hs_d       = HS_HOLD;
            hold_cnt_d = '0;
          end
        end
        HS_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            hs_d       = HS_REPEAT;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
            repeat_d   = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
        HS_REPEAT: begin
          if (rep_cnt_q == REP_LAST) begin
            rep_cnt_d = '0;
            repeat_d  = 1'b1;
          end else begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
          end
        end
        default: begin
          hs_d       = HS_IDLE;
          hold_cnt_d = '0;
          rep_cnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q       <= HS_IDLE;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      repeat_q   <= 1'b0;
    end else begin
      hs_q       <= hs_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      repeat_q   <= repeat_d;
    end
  end

  assign repeat_o = repeat_q;
`else
  assign repeat_o = 1'b0;
`endif

endmodule : btn_channel

// File: rtl/btn_bank_ctrl.sv
// -----------------------------------------------------------------------------
// btn_bank_ctrl
// N-channel push-button front end. Each channel is an independent
// btn_channel (sync + debounce + optional hold/auto-repeat); this level only
// replicates them and ORs the press flags into o_any_down.
//
// Optional feature macro: BTN_BANK_AUTOREPEAT_EN
//   defined   : per-channel hold FSM drives o_flag_btn_repeat
//   undefined : o_flag_btn_repeat is constant 0; HOLD_CYCLES and
//               REPEAT_CYCLES are only range-checked
//
// Ports:
//   clk                in   system clock
//   rst                in   synchronous reset, active-high
//   i_btn              in   [N_BTN] raw asynchronous button pins
//   o_btn_state        out  [N_BTN] debounced level, 1 = pressed
//   o_flag_btn_down    out  [N_BTN] 1-cycle pulse on accepted press
//   o_flag_btn_up      out  [N_BTN] 1-cycle pulse on accepted release
//   o_flag_btn_repeat  out  [N_BTN] 1-cycle pulse per auto-repeat tick
//   o_any_down         out  OR of o_flag_btn_down
// -----------------------------------------------------------------------------
module btn_bank_ctrl
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN           = 4,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_btn_state,
  output logic [N_BTN-1:0] o_flag_btn_down,
  output logic [N_BTN-1:0] o_flag_btn_up,
  output logic [N_BTN-1:0] o_flag_btn_repeat,
  output logic             o_any_down
);

  // Elaboration-time guard: zero-length timings would make the terminal
  // counts underflow, and the bank is limited to one 32-bit word of pins.
  if (N_BTN < 1 || N_BTN > MAX_BTN ||
      DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("btn_bank_ctrl: illegal parameter set");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
`ifdef BTN_BANK_AUTOREPEAT_EN
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
`endif
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_channel (
      .clk      (clk),
      .rst      (rst),
      .btn_i    (i_btn[i]),
      .state_o  (o_btn_state[i]),
      .down_o   (o_flag_btn_down[i]),
      .up_o     (o_flag_btn_up[i]),
      .repeat_o (o_flag_btn_repeat[i])
    );
  end

  // Built from registered flags, so it is glitch-free and aligned with them.
  assign o_any_down = |o_flag_btn_down;

endmodule : btn_bank_ctrl
